// File: rtl/fifo_link_tx.sv
// ---------------------------------------------------------------------------
// fifo_link_tx
//
// Read side of a router input FIFO. The FIFO (fifo_mem) has a 1-cycle read
// latency and is not show-ahead. This block pops packets from it and stages
// them in a 2-entry output buffer (head + spare). It then presents them to
// the downstream link with a req/gnt handshake. While the FIFO is non-empty
// and tx_gnt stays high, it sustains one packet per cycle.
//
// Optional feature macro: TX_PKT_CNT_EN
//   defined   -> tx_pkt_cnt port exists and counts accepted packets (wraps)
//   undefined -> no counter, no tx_pkt_cnt port
//
// Parameters
//   DATA_W       packet width (matches the FIFO output width)
//   CNT_W        sent-packet counter width (TX_PKT_CNT_EN only)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   tx_en        1 = may issue new FIFO reads, 0 = only drain what is buffered
//   fifo_empty   FIFO empty flag
//   fifo_q       FIFO read data, valid the cycle after fifo_rd_req
//   fifo_rd_req  FIFO pop request (combinational)
//   tx_req       packet valid on tx_data
//   tx_data      packet to downstream (the head entry)
//   tx_gnt       downstream accepts tx_data this cycle when tx_req=1
//   idle         nothing buffered and no read in flight
//   tx_pkt_cnt   number of packets sent (TX_PKT_CNT_EN only)
// ---------------------------------------------------------------------------
module fifo_link_tx #(
    parameter int DATA_W = 36,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rd_req,
    output logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_gnt,
    output logic              idle
`ifdef TX_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]  tx_pkt_cnt
`endif
);

    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic              inflight_reg;
    logic [DATA_W-1:0] head_reg;
    logic [DATA_W-1:0] spare_reg;

    logic              xfer;
    logic [2:0]        level_after;
    logic              head_free;
    logic              head_from_spare;
    logic              head_from_fifo;
    logic              spare_from_fifo;

    assign tx_req  = (occ_reg != 2'd0);
    assign tx_data = head_reg;
    assign xfer    = tx_req & tx_gnt;
    assign idle    = (occ_reg == 2'd0) & ~inflight_reg;

    // Buffer level after this cycle's capture and pop. It never exceeds 2,
    // because a read is only issued when room is guaranteed. It never goes
    // negative, because xfer needs occ >= 1.
    assign level_after = {1'b0, occ_reg} + {2'b0, inflight_reg} - {2'b0, xfer};
    assign occ_next    = level_after[1:0];

    // rst_n is folded in so that no pop is requested while reset is held.
    // A pop issued during reset would lose a packet that nobody captures.
    assign fifo_rd_req = rst_n & tx_en & ~fifo_empty & (level_after < 3'd2);

    // The head is free for this cycle's capture if it is empty now, or if
    // it is the only entry and is being popped.
    assign head_free       = (occ_reg == 2'd0) | ((occ_reg == 2'd1) & xfer);
    assign head_from_spare = xfer & (occ_reg == 2'd2);
    assign head_from_fifo  = inflight_reg & head_free;
    assign spare_from_fifo = inflight_reg & ~head_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            spare_reg    <= '0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd_req;

            if (head_from_fifo) begin
                head_reg <= fifo_q;
            end else if (head_from_spare) begin
                head_reg <= spare_reg;
            end

            if (spare_from_fifo) begin
                spare_reg <= fifo_q;
            end
        end
    end

`ifdef TX_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_cnt_reg;

    // Wraps naturally from all-ones back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_reg <= '0;
        end else if (xfer) begin
            pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
        end
    end

    assign tx_pkt_cnt = pkt_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_link_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_link_tx
//
// Directed testbench for fifo_link_tx. A small behavioural FIFO with 1-cycle
// read latency stands in for fifo_mem. The bench drives inputs and samples
// outputs 1 time unit after the rising edge. It checks the combinational
// fifo_rd_req 1 time unit after changing inputs.
// ---------------------------------------------------------------------------
module tb_fifo_link_tx;

    localparam int DATA_W = 36;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tx_en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rd_req;
    logic              tx_req;
    logic [DATA_W-1:0] tx_data;
    logic              tx_gnt;
    logic              idle;
`ifdef TX_PKT_CNT_EN
    logic [CNT_W-1:0]  tx_pkt_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_link_tx #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_en       (tx_en),
        .fifo_empty  (fifo_empty),
        .fifo_q      (fifo_q),
        .fifo_rd_req (fifo_rd_req),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_gnt      (tx_gnt),
        .idle        (idle)
`ifdef TX_PKT_CNT_EN
        ,
        .tx_pkt_cnt  (tx_pkt_cnt)
`endif
    );

    // Behavioural source FIFO: pops on the rd_req edge, and the data is
    // valid for the whole following cycle.
    logic [DATA_W-1:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_req && (rd_ptr != wr_ptr)) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [DATA_W-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %-18s observed %0h expected %0h ok", tag, obs, exp);
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fifo_q = '0;
        rst_n  = 1'b0;
        tx_en  = 1'b1;
        tx_gnt = 1'b0;
        #1;
        chk("rst_tx_req", tx_req, 0);
        chk("rst_idle", idle, 1);
        chk("rst_rd_req", fifo_rd_req, 0);
        chk("rst_tx_data", tx_data, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // ---- 1: reset with occ=2 ----
        cyc();
        push(36'hA1); push(36'hA2);
        #1 chk("t1_rd_c0", fifo_rd_req, 1);
        cyc();
        chk("t1_rd_c1", fifo_rd_req, 1);
        cyc();
        cyc();
        chk("t1_occ2_req", tx_req, 1);
        chk("t1_occ2_data", tx_data, 36'hA1);
        chk("t1_occ2_rd", fifo_rd_req, 0);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_req", tx_req, 0);
        chk("t1_rst_data", tx_data, 0);
        chk("t1_rst_idle", idle, 1);
        push(36'h31);
        #1 chk("t1_rst_rd_forced", fifo_rd_req, 0);
        cyc();
        chk("t1_rst_rd_hold", fifo_rd_req, 0);
        rst_n  = 1'b1;
        tx_gnt = 1'b1;
        #1 chk("t1_rel_rd", fifo_rd_req, 1);
        cyc(); cyc();
        chk("t1_post_pkt", {tx_req, tx_data}, {1'b1, 36'h31});
        cyc();
        chk("t1_post_idle", idle, 1);

        // ---- 2: single packet ----
        cyc();
        push(36'h0_1234_5678);
        #1 chk("t2_rd_c0", fifo_rd_req, 1);
        cyc();
        chk("t2_req_c1", tx_req, 0);
        chk("t2_idle_c1", idle, 0);
        cyc();
        chk("t2_pkt_c2", {tx_req, tx_data}, {1'b1, 36'h0_1234_5678});
        cyc();
        chk("t2_idle_c3", idle, 1);
        chk("t2_req_c3", tx_req, 0);

        // ---- 3: streaming 8 packets ----
        cyc();
        for (int i = 1; i <= 8; i++) push(DATA_W'(i));
        cyc();
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk($sformatf("t3_stream_%0d", i), {tx_req, tx_data}, {1'b1, 36'(i)});
        end
        cyc();
        chk("t3_idle", idle, 1);
`ifdef TX_PKT_CNT_EN
        chk("t3_cnt", tx_pkt_cnt, 10);
`endif

        // ---- 4: backpressure ----
        cyc();
        tx_gnt = 1'b0;
        push(36'h11); push(36'h12); push(36'h13); push(36'h14);
        #1 chk("t4_rd_c0", fifo_rd_req, 1);
        cyc();
        cyc();
        cyc();
        chk("t4_full_rd_c3", fifo_rd_req, 0);
        chk("t4_hold_c3", {tx_req, tx_data}, {1'b1, 36'h11});
        cyc();
        chk("t4_full_rd_c4", fifo_rd_req, 0);
        chk("t4_hold_c4", {tx_req, tx_data}, {1'b1, 36'h11});
        cyc();
        tx_gnt = 1'b1;
        #1 chk("t4_full_xfer_rd", fifo_rd_req, 1);
        chk("t4_pkt_1", {tx_req, tx_data}, {1'b1, 36'h11});
        cyc();
        chk("t4_pkt_2", {tx_req, tx_data}, {1'b1, 36'h12});
        cyc();
        chk("t4_pkt_3", {tx_req, tx_data}, {1'b1, 36'h13});
        cyc();
        chk("t4_pkt_4", {tx_req, tx_data}, {1'b1, 36'h14});
        cyc();
        chk("t4_idle", idle, 1);

        // ---- 5: enable gating ----
        cyc();
        push(36'h21); push(36'h22); push(36'h23); push(36'h24);
        cyc();
        cyc();
        chk("t5_pkt_a", {tx_req, tx_data}, {1'b1, 36'h21});
        tx_en = 1'b0;
        #1 chk("t5_rd_off_c2", fifo_rd_req, 0);
        cyc();
        chk("t5_pkt_b", {tx_req, tx_data}, {1'b1, 36'h22});
        chk("t5_rd_off_c3", fifo_rd_req, 0);
        cyc();
        chk("t5_req_off_c4", tx_req, 0);
        chk("t5_idle_c4", idle, 1);
        chk("t5_rd_off_c4", fifo_rd_req, 0);
        cyc();
        chk("t5_idle_c5", idle, 1);
        chk("t5_rd_off_c5", fifo_rd_req, 0);
        tx_en = 1'b1;
        #1 chk("t5_rd_on", fifo_rd_req, 1);
        cyc();
        cyc();
        chk("t5_pkt_c", {tx_req, tx_data}, {1'b1, 36'h23});
`ifdef TX_PKT_CNT_EN
        chk("t6_cnt_wrap0", tx_pkt_cnt, 0);
`endif
        cyc();
        chk("t5_pkt_d", {tx_req, tx_data}, {1'b1, 36'h24});
`ifdef TX_PKT_CNT_EN
        chk("t6_cnt_17", tx_pkt_cnt, 1);
`endif
        cyc();
        chk("t5_idle_end", idle, 1);
`ifdef TX_PKT_CNT_EN
        chk("t6_cnt_18", tx_pkt_cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
